// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Counter must be able to hold the value N.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_div_unit_rca.sv
// N-bit ripple-carry adder; the subtract path is formed by the caller (~y, cin=1).
module mul_div_unit_rca #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per cycle, results held in hi/lo.
module mul_div_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    import mdu_pkg::*;

    localparam int unsigned    CNT_W   = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [N-1:0]   ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N  = {{(2*N-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     acc_hi_q, acc_hi_d;
    logic [N-1:0]     acc_lo_q, acc_lo_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     a_orig_q, a_orig_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;

    // Operand conditioning at accept
    op_e          op_in;
    logic         in_signed, in_div;
    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;

    assign op_in     = op_e'(op);
    assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign in_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
    assign a_neg     = in_signed & a[N-1];
    assign b_neg     = in_signed & b[N-1];
    assign a_mag     = a_neg ? (~a + ONE) : a;
    assign b_mag     = b_neg ? (~b + ONE) : b;

    // Shared adder: acc_hi + mcand for multiply, shifted remainder - divisor for divide
    logic         is_mul;
    logic [N-1:0] rem_sh;
    logic [N-1:0] rca_x, rca_y, rca_sum;
    logic         rca_cin, rca_cout;

    assign is_mul  = (op_q == OP_MULTU) || (op_q == OP_MULT);
    assign rem_sh  = {acc_hi_q[N-2:0], acc_lo_q[N-1]};
    assign rca_x   = is_mul ? acc_hi_q : rem_sh;
    assign rca_y   = is_mul ? mcand_q : ~mcand_q;
    assign rca_cin = ~is_mul;

    mul_div_unit_rca #(
        .N(N)
    ) u_rca (
        .x   (rca_x),
        .y   (rca_y),
        .cin (rca_cin),
        .sum (rca_sum),
        .cout(rca_cout)
    );

    logic [N:0] mul_ext;
    logic       qbit;

    assign mul_ext = acc_lo_q[0] ? {rca_cout, rca_sum} : {1'b0, acc_hi_q};
    // The bit shifted out of rem makes the trial exceed any N-bit divisor.
    assign qbit    = acc_hi_q[N-1] | rca_cout;

    // Sign fix-up incrementers, independent of the RCA
    logic [2*N-1:0] prod, prod_neg;
    logic [N-1:0]   quo_neg, rem_neg;

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_neg = ~prod + ONE_2N;
    assign quo_neg  = ~acc_lo_q + ONE;
    assign rem_neg  = ~acc_hi_q + ONE;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        a_orig_d = a_orig_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    op_d     = op_in;
                    cnt_d    = '0;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    a_orig_d = a;
                    dbz_d    = in_div && (b == '0);
                    acc_hi_d = '0;
                    acc_lo_d = in_div ? a_mag : b_mag;
                    mcand_d  = in_div ? b_mag : a_mag;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_ONE;
                if (is_mul) begin
                    acc_hi_d = mul_ext[N:1];
                    acc_lo_d = {mul_ext[0], acc_lo_q[N-1:1]};
                end else begin
                    acc_hi_d = qbit ? rca_sum : rem_sh;
                    acc_lo_d = {acc_lo_q[N-2:0], qbit};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_mul) begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? prod_neg : prod;
                end else if (dbz_q) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = sign_a_q ? rem_neg : acc_hi_q;
                    lo_d = (sign_a_q ^ sign_b_q) ? quo_neg : acc_lo_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULTU;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            a_orig_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            a_orig_q <= a_orig_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
